// File: rtl/pc_ctrl.sv
// Next-PC sequencer: selects reset vector, +4, branch/jump target, trap vector,
// trap return or hold each cycle, and tracks boot delay, trap and halt state.
module pc_ctrl #(
   parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
   parameter int unsigned BOOT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap,
   input  logic        mret,
   output logic [31:0] pc_next,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic [1:0]  state,
   output logic        running
);

   localparam logic [1:0] StBoot = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StTrap = 2'd2;
   localparam logic [1:0] StHalt = 2'd3;

   localparam logic [1:0] CauseExt   = 2'd1;
   localparam logic [1:0] CauseAlign = 2'd2;

   localparam logic [31:0] LastBoot = 32'(BOOT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] boot_cnt_q, boot_cnt_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  cause_q, cause_d;

   logic [31:0] target;
   logic        redirect;
   logic        fault;
   logic [1:0]  fault_cause;

   // Redirect target: jump has priority over a taken branch
   always_comb begin
      target   = jump ? jump_target : br_target;
      redirect = jump | br_taken;
   end

   // Next PC and next state selection
   always_comb begin
      pc_next     = pc_in;
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      fault       = 1'b0;
      fault_cause = 2'd0;

      case (state_q)
         StBoot: begin
            pc_next = RESET_VEC;
            if (boot_cnt_q == LastBoot) begin
               state_d = StRun;
            end else begin
               boot_cnt_d = boot_cnt_q + 32'd1;
            end
         end

         StRun, StTrap: begin
            if (!stall) begin
               if (trap) begin
                  fault       = 1'b1;
                  fault_cause = CauseExt;
               end else if (mret && (state_q == StTrap)) begin
                  pc_next = epc_q;
                  state_d = StRun;
               end else if (redirect) begin
                  if (target[1:0] != 2'b00) begin
                     fault       = 1'b1;
                     fault_cause = CauseAlign;
                  end else begin
                     pc_next = target;
                  end
               end else begin
                  pc_next = pc_in + 32'd4;
               end

               // A fault while already in TRAP is a double fault: freeze and halt
               if (fault) begin
                  if (state_q == StRun) begin
                     epc_d   = pc_in;
                     cause_d = fault_cause;
                     pc_next = TRAP_VEC;
                     state_d = StTrap;
                  end else begin
                     pc_next = pc_in;
                     state_d = StHalt;
                  end
               end
            end
         end

         default: begin
            pc_next = pc_in;
         end
      endcase
   end

   // State, boot counter, EPC and cause registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         boot_cnt_q <= 32'd0;
         epc_q      <= 32'd0;
         cause_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
      end
   end

   // Registered status outputs
   always_comb begin
      epc     = epc_q;
      cause   = cause_q;
      state   = state_q;
      running = (state_q == StRun) || (state_q == StTrap);
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;
   localparam int          BC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] pc_in;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'd0;
   logic        trap = 1'b0;
   logic        mret = 1'b0;
   logic [31:0] pc_next;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic [1:0]  state;
   logic        running;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_ctrl #(
      .RESET_VEC  (RV),
      .TRAP_VEC   (TV),
      .BOOT_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jump       (jump),
      .jump_target(jump_target),
      .trap       (trap),
      .mret       (mret),
      .pc_next    (pc_next),
      .epc        (epc),
      .cause      (cause),
      .state      (state),
      .running    (running)
   );

   // The pc register the sequencer drives
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_in <= RV;
      else        pc_in <= pc_next;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 boot, 1 run, 2 trap, 3 halt
   int          m_mode, m_boot;
   logic [31:0] m_epc;
   logic [1:0]  m_cause;
   int          n_mode, n_boot;
   logic [31:0] n_epc;
   logic [1:0]  n_cause;

   always @(negedge clk) begin : compare
      logic [31:0] e_pc;
      logic [31:0] tgt;
      logic        flt;
      logic [1:0]  code;
      n_mode  = m_mode;
      n_boot  = m_boot;
      n_epc   = m_epc;
      n_cause = m_cause;
      e_pc    = pc_in;
      flt     = 1'b0;
      code    = 2'd0;
      if (!rst_n) begin
         e_pc = RV; n_mode = 0; n_boot = 0; n_epc = 32'd0; n_cause = 2'd0;
      end else if (m_mode == 0) begin
         e_pc   = RV;
         n_boot = m_boot + 1;
         if (m_boot == BC - 1) n_mode = 1;
      end else if (m_mode == 3) begin
         e_pc = pc_in;
      end else if (!stall) begin
         if (trap) begin
            flt = 1'b1; code = 2'd1;
         end else if (mret && m_mode == 2) begin
            e_pc = m_epc; n_mode = 1;
         end else if (jump || br_taken) begin
            tgt = jump ? jump_target : br_target;
            if (tgt % 4 != 0) begin
               flt = 1'b1; code = 2'd2;
            end else begin
               e_pc = tgt;
            end
         end else begin
            e_pc = pc_in + 32'd4;
         end
         if (flt && m_mode == 1) begin
            n_epc = pc_in; n_cause = code; e_pc = TV; n_mode = 2;
         end else if (flt) begin
            e_pc = pc_in; n_mode = 3;
         end
      end
      check("pc_next", pc_next, e_pc);
      check("state", 32'(state), 32'(m_mode));
      check("epc", epc, m_epc);
      check("cause", 32'(cause), 32'(m_cause));
      check("running", 32'(running), (m_mode == 1 || m_mode == 2) ? 32'd1 : 32'd0);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0; m_boot <= 0; m_epc <= 32'd0; m_cause <= 2'd0;
      end else begin
         m_mode <= n_mode; m_boot <= n_boot; m_epc <= n_epc; m_cause <= n_cause;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input logic [31:0] a);
      jump = 1'b1; jump_target = a;
      tick();
      jump = 1'b0;
   endtask

   task automatic boot_up();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (BC) tick();
   endtask

   logic [31:0] boot_seq [7];
   logic [31:0] r_tgt;

   initial begin
      boot_seq = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
      #1 rst_n = 1'b0;
      tick();
      tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc_next", pc_next, RV);
      check("rst_running", 32'(running), 32'd0);
      rst_n = 1'b1;
      check("boot_pc0", pc_in, 32'h0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("boot_pc", pc_in, boot_seq[i]);
         check("boot_state", 32'(state), (i >= 3) ? 32'd1 : 32'd0);
         check("boot_running", 32'(running), (i >= 3) ? 32'd1 : 32'd0);
      end

      // Branch, jump-over-branch, stall with a held branch
      go_to(32'h20);
      check("goto_20", pc_in, 32'h20);
      br_taken = 1'b1; br_target = 32'h80;
      tick();
      check("branch", pc_in, 32'h80);
      jump = 1'b1; jump_target = 32'h40;
      tick();
      check("jump_wins", pc_in, 32'h40);
      jump = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold", pc_in, 32'h40);
      end
      stall = 1'b0; br_taken = 1'b0;

      // External trap, return, mret ignored in RUN
      go_to(32'h34);
      trap = 1'b1;
      tick();
      trap = 1'b0;
      check("trap_pc", pc_in, 32'h100);
      check("trap_epc", epc, 32'h34);
      check("trap_cause", 32'(cause), 32'd1);
      check("trap_state", 32'(state), 32'd2);
      mret = 1'b1;
      tick();
      check("mret_pc", pc_in, 32'h34);
      check("mret_state", 32'(state), 32'd1);
      tick();
      mret = 1'b0;
      check("mret_run_pc", pc_in, 32'h38);

      // Misaligned jump, then double fault into HALT
      go_to(32'h10);
      go_to(32'h42);
      check("misalign_pc", pc_in, 32'h100);
      check("misalign_epc", epc, 32'h10);
      check("misalign_cause", 32'(cause), 32'd2);
      trap = 1'b1;
      tick();
      trap = 1'b0;
      check("halt_state", 32'(state), 32'd3);
      for (int i = 0; i < 10; i++) begin
         jump = 1'($urandom); br_taken = 1'($urandom); mret = 1'($urandom);
         trap = 1'($urandom); jump_target = $urandom & 32'hFFFF_FFFC;
         tick();
         check("halt_pc", pc_in, 32'h100);
      end
      jump = 1'b0; br_taken = 1'b0; mret = 1'b0; trap = 1'b0;
      check("halt_epc", epc, 32'h10);
      check("halt_running", 32'(running), 32'd0);

      // Asynchronous reset while in TRAP
      boot_up();
      go_to(32'h50);
      trap = 1'b1;
      tick();
      trap = 1'b0;
      check("pre_rst_state", 32'(state), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_state", 32'(state), 32'd0);
      check("async_epc", epc, 32'd0);
      check("async_cause", 32'(cause), 32'd0);
      check("async_pc_next", pc_next, 32'd0);
      check("async_running", 32'(running), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (BC) tick();

      // Increment wraps modulo 2^32
      go_to(32'hFFFF_FFFC);
      check("wrap_pre", pc_in, 32'hFFFF_FFFC);
      tick();
      check("wrap", pc_in, 32'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (m_mode == 3 && ($urandom % 4) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         stall    = ($urandom % 8) == 0;
         trap     = ($urandom % 16) == 0;
         mret     = ($urandom % 8) == 0;
         jump     = ($urandom % 6) == 0;
         br_taken = ($urandom % 4) == 0;
         r_tgt = $urandom;
         if (($urandom % 8) != 0) r_tgt[1:0] = 2'b00;
         jump_target = r_tgt;
         r_tgt = $urandom;
         if (($urandom % 8) != 0) r_tgt[1:0] = 2'b00;
         br_target = r_tgt;
         tick();
      end
      stall = 1'b0; trap = 1'b0; mret = 1'b0; jump = 1'b0; br_taken = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
